// File: rtl/ym_timer_bank.sv
// Bank of NUM_TIMERS up-counting interval timers with per-timer prescaler,
// reload register, run control, overflow pulse and IRQ-enabled status flag.
module ym_timer_bank #(
  parameter int          NUM_TIMERS = 2,
  parameter int          CNT_W      = 10,
  parameter logic [31:0] DIV_LOG2   = 32'h40
) (
  input  logic                        MCLK,
  input  logic                        IC,
  input  logic                        tick,
  input  logic                        rl_wr,
  input  logic [2:0]                  rl_sel,
  input  logic [CNT_W-1:0]            rl_data,
  input  logic                        ctrl_wr,
  input  logic [NUM_TIMERS-1:0]       ctrl_load,
  input  logic [NUM_TIMERS-1:0]       ctrl_irq_en,
  input  logic [NUM_TIMERS-1:0]       ctrl_clr,
  output logic [NUM_TIMERS-1:0]       flag,
  output logic                        irq,
  output logic [NUM_TIMERS-1:0]       ovf_pulse,
  output logic [NUM_TIMERS*CNT_W-1:0] cnt_o
);

  function automatic logic at_top(input logic [CNT_W-1:0] c);
    return &c;
  endfunction

  // All-ones wraps back to the reload value instead of rolling to zero.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c,
                                                  input logic [CNT_W-1:0] reload);
    logic [CNT_W-1:0] inc;
    inc = c + 1'b1;
    return at_top(c) ? reload : inc;
  endfunction

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
    localparam int DIV = int'(DIV_LOG2[4*i +: 4]);
    localparam int PW  = (DIV == 0) ? 1 : DIV;

    logic [CNT_W-1:0] reload_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    presc_q;
    logic             run_q;
    logic             irq_en_q;
    logic             flag_q;
    logic             ovf_q;
    logic             load_edge;
    logic             run_keep;
    logic             step_en;
    logic             cnt_step;
    logic             wrap;

    // A stop write in the same cycle as a tick freezes the count before it.
    always_comb begin
      load_edge = ctrl_wr & ctrl_load[i] & ~run_q;
      run_keep  = run_q & (~ctrl_wr | ctrl_load[i]);
      step_en   = tick & run_keep;
      cnt_step  = step_en & ((DIV == 0) ? 1'b1 : (&presc_q));
      wrap      = cnt_step & at_top(cnt_q);
    end

    always_ff @(posedge MCLK or negedge IC) begin
      if (!IC) begin
        reload_q <= '0;
        cnt_q    <= '0;
        presc_q  <= '0;
        run_q    <= 1'b0;
        irq_en_q <= 1'b0;
        flag_q   <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        if (rl_wr && (rl_sel == 3'(i))) begin
          reload_q <= rl_data;
        end
        if (ctrl_wr) begin
          run_q    <= ctrl_load[i];
          irq_en_q <= ctrl_irq_en[i];
        end
        // Load and overflow both sample reload_q before any same-cycle write.
        if (load_edge) begin
          cnt_q   <= reload_q;
          presc_q <= '0;
        end else if (step_en) begin
          presc_q <= presc_q + 1'b1;
          if (cnt_step) begin
            cnt_q <= next_count(cnt_q, reload_q);
          end
        end
        ovf_q <= wrap;
        if (wrap && irq_en_q) begin
          flag_q <= 1'b1;
        end else if (ctrl_wr && ctrl_clr[i]) begin
          flag_q <= 1'b0;
        end
      end
    end

    assign cnt_o[i*CNT_W +: CNT_W] = cnt_q;
    assign flag[i]                 = flag_q;
    assign ovf_pulse[i]            = ovf_q;
  end

  assign irq = |flag;

endmodule

// File: tb/tb_ym_timer_bank.sv
// Directed-vector bench for ym_timer_bank: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_ym_timer_bank;

  logic        MCLK;
  logic        IC;
  logic        tick;
  logic        rl_wr;
  logic [2:0]  rl_sel;
  logic [9:0]  rl_data;
  logic        ctrl_wr;
  logic [1:0]  ctrl_load;
  logic [1:0]  ctrl_irq_en;
  logic [1:0]  ctrl_clr;
  logic [1:0]  flag;
  logic        irq;
  logic [1:0]  ovf_pulse;
  logic [19:0] cnt_o;

  ym_timer_bank #(.NUM_TIMERS(2), .CNT_W(10), .DIV_LOG2(32'h40)) dut (
    .MCLK(MCLK), .IC(IC), .tick(tick), .rl_wr(rl_wr), .rl_sel(rl_sel),
    .rl_data(rl_data), .ctrl_wr(ctrl_wr), .ctrl_load(ctrl_load),
    .ctrl_irq_en(ctrl_irq_en), .ctrl_clr(ctrl_clr), .flag(flag), .irq(irq),
    .ovf_pulse(ovf_pulse), .cnt_o(cnt_o)
  );

  typedef struct {
    string      name;
    logic [1:0] flag;
    logic [1:0] ovf;
    logic [9:0] c0;
    logic [9:0] c1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  always @(negedge MCLK) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors++;
      if (flag !== mon_e.flag || ovf_pulse !== mon_e.ovf || irq !== (|mon_e.flag) ||
          cnt_o[9:0] !== mon_e.c0 || cnt_o[19:10] !== mon_e.c1) begin
        miscompares++;
        $display("FAIL %s: got flag=%b ovf=%b irq=%b cnt0=%h cnt1=%h, want flag=%b ovf=%b irq=%b cnt0=%h cnt1=%h",
                 mon_e.name, flag, ovf_pulse, irq, cnt_o[9:0], cnt_o[19:10],
                 mon_e.flag, mon_e.ovf, |mon_e.flag, mon_e.c0, mon_e.c1);
      end
    end
  end

  task automatic clk();
    @(posedge MCLK);
    #1;
    tick    = 1'b0;
    rl_wr   = 1'b0;
    ctrl_wr = 1'b0;
  endtask

  task automatic ctrl(input logic [1:0] ld, input logic [1:0] ie, input logic [1:0] cl);
    ctrl_wr     = 1'b1;
    ctrl_load   = ld;
    ctrl_irq_en = ie;
    ctrl_clr    = cl;
  endtask

  task automatic rl(input logic [2:0] s, input logic [9:0] d);
    rl_wr   = 1'b1;
    rl_sel  = s;
    rl_data = d;
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      tick = 1'b1;
      clk();
    end
  endtask

  task automatic ex(input string nm, input logic [1:0] f, input logic [1:0] o,
                    input logic [9:0] a, input logic [9:0] b);
    exp_t e;
    e.name = nm;
    e.flag = f;
    e.ovf  = o;
    e.c0   = a;
    e.c1   = b;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0;
    IC = 1'b0; tick = 1'b0; rl_wr = 1'b0; rl_sel = 3'd0; rl_data = 10'h0;
    ctrl_wr = 1'b0; ctrl_load = 2'b00; ctrl_irq_en = 2'b00; ctrl_clr = 2'b00;
    clk(); clk();
    ex("reset", 2'b00, 2'b00, 10'h000, 10'h000);
    clk();
    IC = 1'b1;

    // basic 3-tick overflow on timer0 (divide by 1)
    rl(3'd0, 10'h3FD); clk();
    ex("rl_no_touch", 2'b00, 2'b00, 10'h000, 10'h000);
    ctrl(2'b01, 2'b01, 2'b00); clk();
    ex("load0", 2'b00, 2'b00, 10'h3FD, 10'h000);
    tk(1); ex("t1", 2'b00, 2'b00, 10'h3FE, 10'h000);
    tk(1); ex("t2", 2'b00, 2'b00, 10'h3FF, 10'h000);
    tk(1); ex("wrap0", 2'b01, 2'b01, 10'h3FD, 10'h000);
    clk(); ex("pulse_end", 2'b01, 2'b00, 10'h3FD, 10'h000);

    // timer1 divide-by-16, timer0 stopped with its flag retained
    rl(3'd1, 10'h3FF); clk();
    ctrl(2'b10, 2'b10, 2'b00); clk();
    ex("load1", 2'b01, 2'b00, 10'h3FD, 10'h3FF);
    for (int k = 0; k < 15; k++) begin
      tk(1); ex("presc", 2'b01, 2'b00, 10'h3FD, 10'h3FF);
    end
    tk(1); ex("wrap1", 2'b11, 2'b10, 10'h3FD, 10'h3FF);
    for (int k = 0; k < 15; k++) begin
      tk(1); ex("presc2", 2'b11, 2'b00, 10'h3FD, 10'h3FF);
    end
    tk(1); ex("wrap1b", 2'b11, 2'b10, 10'h3FD, 10'h3FF);

    // flag clear, pulse without flag, set-wins-over-clear
    ctrl(2'b00, 2'b00, 2'b11); clk();
    ex("clr_all", 2'b00, 2'b00, 10'h3FD, 10'h3FF);
    ctrl(2'b01, 2'b00, 2'b00); clk();
    ex("load0b", 2'b00, 2'b00, 10'h3FD, 10'h3FF);
    tk(3); ex("noflag", 2'b00, 2'b01, 10'h3FD, 10'h3FF);
    ctrl(2'b01, 2'b01, 2'b00); clk();
    ex("rewrite", 2'b00, 2'b00, 10'h3FD, 10'h3FF);
    tk(3); ex("flag0", 2'b01, 2'b01, 10'h3FD, 10'h3FF);
    ctrl(2'b01, 2'b01, 2'b01); clk();
    ex("clr0", 2'b00, 2'b00, 10'h3FD, 10'h3FF);
    tk(2);
    ctrl(2'b01, 2'b01, 2'b01); tk(1);
    ex("setwins", 2'b01, 2'b01, 10'h3FD, 10'h3FF);

    // stop freezes, restart reloads and ignores the coincident tick
    tk(1); ex("pre_stop", 2'b01, 2'b00, 10'h3FE, 10'h3FF);
    ctrl(2'b00, 2'b01, 2'b01); clk();
    ex("stop", 2'b00, 2'b00, 10'h3FE, 10'h3FF);
    tk(5); ex("frozen", 2'b00, 2'b00, 10'h3FE, 10'h3FF);
    ctrl(2'b01, 2'b01, 2'b00); tk(1);
    ex("restart", 2'b00, 2'b00, 10'h3FD, 10'h3FF);
    tk(1); ex("after_restart", 2'b00, 2'b00, 10'h3FE, 10'h3FF);

    // reload update mid-count and same-cycle load/reload write
    rl(3'd0, 10'h300); clk();
    ex("rl_mid", 2'b00, 2'b00, 10'h3FE, 10'h3FF);
    tk(2); ex("wrap_new_rl", 2'b01, 2'b01, 10'h300, 10'h3FF);
    tk(1); ex("new_period", 2'b01, 2'b00, 10'h301, 10'h3FF);
    ctrl(2'b00, 2'b00, 2'b01); clk();
    ex("stop2", 2'b00, 2'b00, 10'h301, 10'h3FF);
    rl(3'd0, 10'h3F0); ctrl(2'b01, 2'b00, 2'b00); clk();
    ex("load_old_rl", 2'b00, 2'b00, 10'h300, 10'h3FF);
    ctrl(2'b00, 2'b00, 2'b00); clk();
    ctrl(2'b01, 2'b00, 2'b00); clk();
    ex("load_new_rl", 2'b00, 2'b00, 10'h3F0, 10'h3FF);

    // out-of-range reload select ignored; simultaneous overflows
    rl(3'd5, 10'h000); clk();
    ctrl(2'b11, 2'b11, 2'b00); clk();
    ex("load_both", 2'b00, 2'b00, 10'h3F0, 10'h3FF);
    tk(15); ex("pre_sim", 2'b00, 2'b00, 10'h3FF, 10'h3FF);
    tk(1); ex("sim_ovf", 2'b11, 2'b11, 10'h3F0, 10'h3FF);
    tk(1);

    // asynchronous reset between edges
    #1;
    IC = 1'b0;
    ex("async_rst", 2'b00, 2'b00, 10'h000, 10'h000);
    clk();
    IC = 1'b1;
    tk(3); ex("dead", 2'b00, 2'b00, 10'h000, 10'h000);
    ctrl(2'b01, 2'b01, 2'b00); clk();
    ex("reload_after_rst", 2'b00, 2'b00, 10'h000, 10'h000);
    tk(1); ex("count_after_rst", 2'b00, 2'b00, 10'h001, 10'h000);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge MCLK);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
